if_fetch: RTL and testbench

Instruction-fetch stage of the 5-stage core. Owns the PC and issues one instruction-memory request at a time over a req/gnt/rvalid handshake. Presents each fetched instruction as `if_pc`/`if_inst` to the IF/ID pipeline register. It sits at the producing end of the IF/ID interface: it consumes the same `stall` vector and `flush`, and raises `stallreq_if` to the pipeline controller while a fetch is outstanding.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/if_fetch.sv | 118 +++++++++++
 tb/tb_if_fetch.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: bubble values, stall-vector encoding and fetch FSM states.
package cpu_pkg;

  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam int          STAGE_NUM = 6;
  localparam int          IF_STAGE  = 1;
  localparam logic        Stop      = 1'b1;
  localparam logic        NoStop    = 1'b0;

  typedef logic [1:0] fetch_state_e;
  localparam fetch_state_e REQ  = 2'd0;
  localparam fetch_state_e WAIT = 2'd1;
  localparam fetch_state_e HOLD = 2'd2;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, keeps one imem request in flight and
// presents the fetched word to IF/ID, holding it while IF is stopped.
module if_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [STAGE_NUM-1:0] stall,
  input  logic                 flush,
  input  logic [31:0]          new_pc,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          if_pc,
  output logic [31:0]          if_inst,
  output logic                 stallreq_if
);

  logic [31:0]  pc_q;
  logic [31:0]  req_addr_q;
  logic [31:0]  buf_q;
  fetch_state_e state_q;
  logic         drop_q;

  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  pc_inc;
  logic         if_go;
  logic         present_wait;
  logic         present_hold;
  logic         unused_stall;

  assign redirect     = flush | branch_taken;
  assign target       = word_align(flush ? new_pc : branch_target);
  assign pc_inc       = pc_q + 32'd4;
  assign if_go        = (stall[IF_STAGE] == NoStop);
  assign unused_stall = ^stall;

  assign present_wait = (state_q == WAIT) && imem_rvalid && !drop_q && !redirect;
  assign present_hold = (state_q == HOLD) && !redirect;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      state_q    <= REQ;
      drop_q     <= 1'b0;
    end else begin
      case (state_q)
        REQ: begin
          // The address is frozen until gnt; a redirect only marks the response stale.
          if (redirect) drop_q <= 1'b1;
          if (imem_gnt) state_q <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (drop_q) begin
              drop_q     <= 1'b0;
              req_addr_q <= redirect ? target : pc_q;
              state_q    <= REQ;
            end else if (redirect) begin
              req_addr_q <= target;
              state_q    <= REQ;
            end else if (if_go) begin
              pc_q       <= pc_inc;
              req_addr_q <= pc_inc;
              state_q    <= REQ;
            end else begin
              state_q    <= HOLD;
            end
          end else if (redirect) begin
            drop_q <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect) begin
            req_addr_q <= target;
            state_q    <= REQ;
          end else if (if_go) begin
            pc_q       <= pc_inc;
            req_addr_q <= pc_inc;
            state_q    <= REQ;
          end
        end
        default: state_q <= REQ;
      endcase
      if (redirect) pc_q <= target;
    end
  end

  // Stopped instruction is parked here; data path needs no reset.
  always_ff @(posedge clk) begin
    if (present_wait && !if_go) buf_q <= imem_rdata;
  end

  assign imem_req    = rstn && (state_q == REQ);
  assign imem_addr   = req_addr_q;
  assign stallreq_if = rstn && ((state_q == REQ) || ((state_q == WAIT) && !imem_rvalid));

  always_comb begin
    if_pc   = ZeroWord;
    if_inst = NOP;
    if (present_wait) begin
      if_pc   = pc_q;
      if_inst = imem_rdata;
    end else if (present_hold) begin
      if_pc   = pc_q;
      if_inst = buf_q;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: bench drives the imem handshake cycle by cycle
// and checks presented instructions against a scoreboard filled at grant time.
module tb_if_fetch;
  import cpu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

  logic                 clk;
  logic                 rstn;
  logic [STAGE_NUM-1:0] stall;
  logic                 flush;
  logic [31:0]          new_pc;
  logic                 branch_taken;
  logic [31:0]          branch_target;
  logic                 imem_req;
  logic [31:0]          imem_addr;
  logic                 imem_gnt;
  logic                 imem_rvalid;
  logic [31:0]          imem_rdata;
  logic [31:0]          if_pc;
  logic [31:0]          if_inst;
  logic                 stallreq_if;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  logic [31:0] last_addr;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;

  if_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_inst(if_inst), .stallreq_if(stallreq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd, input logic stl);
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = rd;
    stall       = '0;
    stall[IF_STAGE] = stl;
    #1;
  endtask

  task automatic req_cycle(input logic [31:0] ea, input bit keep);
    drive(1'b1, 1'b0, JUNK, NoStop);
    chk("req_valid", 32'(imem_req), 32'd1);
    chk("req_addr", imem_addr, ea);
    chk("req_stallreq", 32'(stallreq_if), 32'd1);
    chk("req_inst", if_inst, NOP);
    last_addr = imem_addr;
    if (keep) sb.push_back({ea, mem(ea)});
    tick();
  endtask

  task automatic req_nogrant(input logic [31:0] ea);
    drive(1'b0, 1'b0, JUNK, NoStop);
    chk("nognt_valid", 32'(imem_req), 32'd1);
    chk("nognt_addr", imem_addr, ea);
    chk("nognt_inst", if_inst, NOP);
    tick();
  endtask

  task automatic wait_cycle();
    drive(1'b0, 1'b0, JUNK, NoStop);
    chk("wait_req", 32'(imem_req), 32'd0);
    chk("wait_stallreq", 32'(stallreq_if), 32'd1);
    chk("wait_pc", if_pc, ZeroWord);
    chk("wait_inst", if_inst, NOP);
    tick();
  endtask

  task automatic resp_cycle(input logic stl);
    logic [63:0] e;
    drive(1'b0, 1'b1, mem(last_addr), stl);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk("resp_pc", if_pc, e[63:32]);
      chk("resp_inst", if_inst, e[31:0]);
      hold_pc   = e[63:32];
      hold_inst = e[31:0];
    end
    chk("resp_req", 32'(imem_req), 32'd0);
    chk("resp_stallreq", 32'(stallreq_if), 32'd0);
    tick();
  endtask

  task automatic resp_drop();
    drive(1'b0, 1'b1, mem(last_addr), NoStop);
    chk("drop_pc", if_pc, ZeroWord);
    chk("drop_inst", if_inst, NOP);
    chk("drop_req", 32'(imem_req), 32'd0);
    tick();
  endtask

  task automatic hold_cycle(input logic stl);
    drive(1'b0, 1'b0, JUNK, stl);
    chk("hold_pc", if_pc, hold_pc);
    chk("hold_inst", if_inst, hold_inst);
    chk("hold_req", 32'(imem_req), 32'd0);
    chk("hold_stallreq", 32'(stallreq_if), 32'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    flush = 1'b0; new_pc = '0; branch_taken = 1'b0; branch_target = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; stall = '0;
    tick();
    tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc", if_pc, ZeroWord);
    chk("rst_inst", if_inst, NOP);
    chk("rst_stallreq", 32'(stallreq_if), 32'd0);
    rstn = 1'b1;

    // free run, including one extra wait cycle
    req_cycle(32'h0, 1); resp_cycle(NoStop);
    req_cycle(32'h4, 1); resp_cycle(NoStop);
    req_cycle(32'h8, 1); wait_cycle(); resp_cycle(NoStop);

    // backpressure: stopped for three cycles from rvalid
    req_cycle(32'hC, 1); resp_cycle(Stop);
    hold_cycle(Stop); hold_cycle(Stop); hold_cycle(NoStop);
    req_cycle(32'h10, 0);

    // branch while waiting; that response must vanish
    branch_taken = 1'b1; branch_target = 32'h100;
    wait_cycle();
    branch_taken = 1'b0;
    wait_cycle();
    resp_drop();
    req_cycle(32'h100, 1); resp_cycle(NoStop);

    // flush beats branch, redirect in REQ without grant
    flush = 1'b1; new_pc = 32'h80; branch_taken = 1'b1; branch_target = 32'h200;
    req_nogrant(32'h104);
    flush = 1'b0; branch_taken = 1'b0;
    req_nogrant(32'h104);
    req_cycle(32'h104, 0);
    resp_drop();
    req_cycle(32'h80, 1); resp_cycle(NoStop);

    // redirect in the rvalid cycle to the top word, then wrap
    req_cycle(32'h84, 0);
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    resp_drop();
    branch_taken = 1'b0;
    req_cycle(32'hFFFF_FFFC, 1); resp_cycle(NoStop);
    req_cycle(32'h0, 1); resp_cycle(NoStop);

    // unaligned target redirected from HOLD
    req_cycle(32'h4, 1); resp_cycle(Stop);
    branch_taken = 1'b1; branch_target = 32'h103;
    drive(1'b0, 1'b0, JUNK, Stop);
    chk("hold_redir_pc", if_pc, ZeroWord);
    chk("hold_redir_inst", if_inst, NOP);
    tick();
    branch_taken = 1'b0;
    req_cycle(32'h100, 1); resp_cycle(NoStop);

    // asynchronous reset while waiting
    req_cycle(32'h104, 0);
    drive(1'b0, 1'b0, JUNK, NoStop);
    rstn = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_inst", if_inst, NOP);
    chk("arst_pc", if_pc, ZeroWord);
    chk("arst_stallreq", 32'(stallreq_if), 32'd0);
    tick();
    rstn = 1'b1;
    #1;
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", imem_addr, RST_PC);
    req_cycle(RST_PC, 1); resp_cycle(NoStop);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
